// File: rtl/pipeline.sv
// Byte-wide ready/valid register pipeline of STAGES stages feeding an internal
// throttled sink that keeps beat count, byte sum and last consumed byte.
module pipeline #(
    parameter int STAGES      = 4,
    parameter int SINK_PERIOD = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [15:0] beat_count,
    output logic [15:0] byte_sum,
    output logic [7:0]  last_byte
);
    localparam logic [7:0] THROTTLE_MAX = 8'(SINK_PERIOD - 1);

    logic [STAGES-1:0] valid_r;
    logic [7:0]        data_r [STAGES];
    logic [STAGES:0]   ready_chain_s;
    logic [STAGES-1:0] up_valid_s;
    logic [7:0]        up_data_s [STAGES];
    logic              sink_ready_s;
    logic              consume_s;
    logic [7:0]        throttle_r;

    // Upstream view of each stage: stage 0 sees the producer, the rest see their predecessor.
    always_comb begin
        up_valid_s    = '0;
        up_data_s[0]  = data;
        up_valid_s[0] = data_valid;
        for (int i = 1; i < STAGES; i++) begin
            up_valid_s[i] = valid_r[i-1];
            up_data_s[i]  = data_r[i-1];
        end
    end

    // Readiness ripples back from the sink so a full pipe still shifts every cycle.
    always_comb begin
        ready_chain_s         = '0;
        sink_ready_s          = (throttle_r == 8'd0);
        ready_chain_s[STAGES] = sink_ready_s;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ready_chain_s[i] = !valid_r[i] || ready_chain_s[i+1];
        end
        consume_s  = valid_r[STAGES-1] && sink_ready_s;
        data_ready = ready_chain_s[0] && !reset;
    end

    // Stage valid bits: load from upstream when the stage can move, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (ready_chain_s[i]) begin
                    valid_r[i] <= up_valid_s[i];
                end
            end
        end
    end

    // Stage data: only a valid upstream byte is captured, so idle-cycle data never enters state.
    always_ff @(posedge clock) begin
        for (int i = 0; i < STAGES; i++) begin
            if (ready_chain_s[i] && up_valid_s[i]) begin
                data_r[i] <= up_data_s[i];
            end
        end
    end

    // Free-running sink throttle and running statistics of consumed beats.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            throttle_r <= 8'd0;
            beat_count <= 16'd0;
            byte_sum   <= 16'd0;
            last_byte  <= 8'd0;
        end else begin
            if (throttle_r == THROTTLE_MAX) begin
                throttle_r <= 8'd0;
            end else begin
                throttle_r <= throttle_r + 8'd1;
            end
            if (consume_s) begin
                beat_count <= beat_count + 16'd1;
                byte_sum   <= byte_sum + {8'd0, data_r[STAGES-1]};
                last_byte  <= data_r[STAGES-1];
            end
        end
    end
endmodule

// File: tb/tb_pipeline.sv
// Directed testbench for pipeline: a default instance plus a throttled
// (SINK_PERIOD=3) instance, with hand-computed expected statistics.
module tb_pipeline;
    logic        clock;
    logic        reset;
    logic [7:0]  data;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] beat_count;
    logic [15:0] byte_sum;
    logic [7:0]  last_byte;

    logic [7:0]  data3;
    logic        valid3;
    logic        ready3;
    logic [15:0] count3;
    logic [15:0] sum3;
    logic [7:0]  last3;

    int total;
    int bad;

    pipeline dut (
        .clock(clock), .reset(reset), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .beat_count(beat_count), .byte_sum(byte_sum),
        .last_byte(last_byte)
    );

    pipeline #(.STAGES(4), .SINK_PERIOD(3)) dut3 (
        .clock(clock), .reset(reset), .data(data3), .data_valid(valid3),
        .data_ready(ready3), .beat_count(count3), .byte_sum(sum3),
        .last_byte(last3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        data_valid = 1'b0;
        valid3     = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        data_valid = 1'b0;
        valid3     = 1'b0;
        data       = 8'd0;
        data3      = 8'd0;
        tick();
        total++;
        if (data_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_low got=%b want=0", data_ready);
        end
        reset = 1'b0;
        #1;
        total++;
        if (data_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_after got=%b want=1", data_ready);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({beat_count, byte_sum, last_byte} !== 40'd0 || data_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got cnt=%h sum=%h last=%h rdy=%b want 0/0/0/1",
                         i, beat_count, byte_sum, last_byte, data_ready);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            data_valid = 1'b1;
            data       = 8'(k);
            total++;
            if (data_ready !== 1'b1) begin
                bad++;
                $display("FAIL basic_ready beat=%0d got=%b want=1", k, data_ready);
            end
            tick();
        end
        data_valid = 1'b0;
        data       = 8'd0;
        // Byte 3 was accepted at the last edge; byte 2 retires 3 edges later, byte 3 at 4.
        tick(); tick(); tick();
        total++;
        if (beat_count !== 16'd2) begin
            bad++;
            $display("FAIL basic_count_t3 got=%0d want=2", beat_count);
        end
        tick();
        total++;
        if (beat_count !== 16'd3 || byte_sum !== 16'd6 || last_byte !== 8'd3) begin
            bad++;
            $display("FAIL basic_stats got cnt=%0d sum=%0d last=%0d want 3/6/3",
                     beat_count, byte_sum, last_byte);
        end
    endtask

    task automatic test_throttle();
        int sent;
        int cyc;
        int last_acc;
        bit dropped;
        bit have_post;
        do_reset();
        sent      = 0;
        cyc       = 0;
        last_acc  = 0;
        dropped   = 1'b0;
        have_post = 1'b0;
        valid3    = 1'b1;
        data3     = 8'hFF;
        while (sent < 12 && cyc < 200) begin
            if (ready3) begin
                if (dropped) begin
                    if (have_post) begin
                        total++;
                        if (cyc - last_acc !== 3) begin
                            bad++;
                            $display("FAIL throttle_gap got=%0d want=3", cyc - last_acc);
                        end
                    end
                    have_post = 1'b1;
                end
                last_acc = cyc;
                sent++;
            end else if (!dropped) begin
                dropped = 1'b1;
                total++;
                if (sent - int'(count3) !== 4) begin
                    bad++;
                    $display("FAIL throttle_fill got=%0d want=4", sent - int'(count3));
                end
            end
            tick();
            cyc++;
        end
        valid3 = 1'b0;
        total++;
        if (!dropped || sent !== 12) begin
            bad++;
            $display("FAIL throttle_stall got dropped=%b sent=%0d want 1/12", dropped, sent);
        end
        cyc = 0;
        while (count3 !== 16'd12 && cyc < 100) begin
            tick();
            cyc++;
        end
        total++;
        if (count3 !== 16'd12 || sum3 !== 16'h0BF4 || last3 !== 8'hFF) begin
            bad++;
            $display("FAIL throttle_stats got cnt=%0d sum=%h last=%h want 12/0bf4/ff",
                     count3, sum3, last3);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] bytes [4];
        bytes[0] = 8'd10;
        bytes[1] = 8'd20;
        bytes[2] = 8'd30;
        bytes[3] = 8'd40;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                data_valid = 1'b1;
                data       = bytes[k/2];
            end else begin
                data_valid = 1'b0;
                data       = 8'bx;
            end
            tick();
        end
        data_valid = 1'b0;
        data       = 8'bx;
        for (int k = 0; k < 6; k++) tick();
        total++;
        if (beat_count !== 16'd4 || byte_sum !== 16'd100 || last_byte !== 8'd40) begin
            bad++;
            $display("FAIL gapped_stats got cnt=%0d sum=%0d last=%0d want 4/100/40",
                     beat_count, byte_sum, last_byte);
        end
    endtask

    // Runs directly after test_gapped so the statistics are non-zero before the reset hits.
    task automatic test_reset_midflight();
        for (int k = 0; k < 4; k++) begin
            data_valid = 1'b1;
            data       = 8'(5 + k);
            tick();
        end
        data_valid = 1'b0;
        data       = 8'd0;
        total++;
        if (beat_count !== 16'd4) begin
            bad++;
            $display("FAIL mid_inflight got=%0d want=4", beat_count);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({beat_count, byte_sum, last_byte} !== 40'd0 || data_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_clear got cnt=%0d sum=%0d last=%0d rdy=%b want 0/0/0/0",
                     beat_count, byte_sum, last_byte, data_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (data_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_ready_release got=%b want=1", data_ready);
        end
        for (int k = 0; k < 10; k++) tick();
        total++;
        if (beat_count !== 16'd0 || byte_sum !== 16'd0) begin
            bad++;
            $display("FAIL mid_no_stale got cnt=%0d sum=%0d want 0/0", beat_count, byte_sum);
        end
    endtask

    task automatic test_wrap();
        int stalls;
        do_reset();
        stalls     = 0;
        data_valid = 1'b1;
        data       = 8'hFF;
        for (int k = 0; k < 258; k++) begin
            if (data_ready !== 1'b1) stalls++;
            tick();
        end
        data_valid = 1'b0;
        total++;
        if (stalls !== 0) begin
            bad++;
            $display("FAIL wrap_stalls got=%0d want=0", stalls);
        end
        for (int k = 0; k < 5; k++) tick();
        // 258 * 255 = 65790, which is 254 (0x00FE) modulo 65536.
        total++;
        if (beat_count !== 16'd258 || byte_sum !== 16'h00FE || last_byte !== 8'hFF) begin
            bad++;
            $display("FAIL wrap_stats got cnt=%0d sum=%h last=%h want 258/00fe/ff",
                     beat_count, byte_sum, last_byte);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_throttle();
        test_gapped();
        test_reset_midflight();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
